// File: rtl/cam_pkg.sv
// cam_pkg: state codes, default timings and display mapping for the camera power sequencer.
package cam_pkg;
  localparam logic [3:0] C_OFF       = 4'd0;
  localparam logic [3:0] C_XCLK      = 4'd1;
  localparam logic [3:0] C_PWDN      = 4'd2;
  localparam logic [3:0] C_SETTLE    = 4'd3;
  localparam logic [3:0] C_INIT_ST   = 4'd4;
  localparam logic [3:0] C_INIT_WAIT = 4'd5;
  localparam logic [3:0] C_READY     = 4'd6;
  localparam logic [3:0] C_FAULT     = 4'd7;
  localparam logic [3:0] C_OFF_RETRY = 4'd8;
  typedef enum logic [3:0] {
    S_OFF        = C_OFF,
    S_XCLK       = C_XCLK,
    S_PWDN       = C_PWDN,
    S_SETTLE     = C_SETTLE,
    S_INIT_START = C_INIT_ST,
    S_INIT_WAIT  = C_INIT_WAIT,
    S_READY      = C_READY,
    S_FAULT      = C_FAULT,
    S_OFF_RETRY  = C_OFF_RETRY
  } state_t;
  localparam logic [31:0] T_XCLK_DEF      = 32'd1000;
  localparam logic [31:0] T_PWDN_DEF      = 32'd1000;
  localparam logic [31:0] T_SETTLE_DEF    = 32'd20000;
  localparam logic [31:0] T_INIT_TO_DEF   = 32'd100000;
  localparam logic [3:0]  MAX_RETRIES_DEF = 4'd3;
  function automatic logic [3:0] seg_code(input state_t s);
    return s;
  endfunction
  // Last timer value of a T-cycle state; a zero duration still lasts one cycle.
  function automatic logic [31:0] t_last(input logic [31:0] t);
    return (t == 32'd0) ? 32'd0 : t - 32'd1;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop level synchroniser for asynchronous inputs.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_meta <= '0;
      o_q    <= '0;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
endmodule

// File: rtl/cam_pwr_seq.sv
// cam_pwr_seq: timed camera power-up sequencer with init handshake and timeout.
// Define CAM_PWR_SEQ_RETRY_EN to power-cycle and retry after an init timeout.
module cam_pwr_seq
  import cam_pkg::*;
#(
  parameter logic [31:0] T_XCLK_US    = T_XCLK_DEF,
  parameter logic [31:0] T_PWDN_US    = T_PWDN_DEF,
  parameter logic [31:0] T_SETTLE_US  = T_SETTLE_DEF,
  parameter logic [31:0] T_INIT_TO_US = T_INIT_TO_DEF,
  parameter logic [3:0]  MAX_RETRIES  = MAX_RETRIES_DEF
) (
  input  logic       clk_1us,
  input  logic       reset,
  input  logic       enable,
  input  logic       init_done,
  output logic       cam_pwdn,
  output logic       cam_rst_n,
  output logic       xclk_en,
  output logic       init_start,
  output logic       ready,
  output logic       fault,
  output logic [3:0] state_out
);
  localparam logic [31:0] L_XCLK   = t_last(T_XCLK_US);
  localparam logic [31:0] L_PWDN   = t_last(T_PWDN_US);
  localparam logic [31:0] L_SETTLE = t_last(T_SETTLE_US);
  localparam logic [31:0] L_INIT   = t_last(T_INIT_TO_US);
  state_t      r_state, w_nxt, w_to_nxt;
  logic [31:0] r_timer;
  logic        w_done;
  sync_2ff #(.W(1)) u_sync (
    .i_clk  (clk_1us),
    .i_rst_n(reset),
    .i_d    (init_done),
    .o_q    (w_done)
  );
`ifdef CAM_PWR_SEQ_RETRY_EN
  logic [3:0] r_retry;
  assign w_to_nxt = (r_retry < MAX_RETRIES) ? S_OFF_RETRY : S_FAULT;
  always_ff @(posedge clk_1us or negedge reset)
    if (!reset) r_retry <= '0;
    else if (!enable || w_nxt == S_READY) r_retry <= '0;
    else if (r_state == S_INIT_WAIT && w_nxt == S_OFF_RETRY) r_retry <= r_retry + 4'd1;
`else
  assign w_to_nxt = S_FAULT;
`endif
  always_comb begin
    w_nxt = r_state;
    if (!enable) w_nxt = S_OFF;
    else
      case (r_state)
        S_OFF:        w_nxt = S_XCLK;
        S_XCLK:       w_nxt = (r_timer == L_XCLK) ? S_PWDN : S_XCLK;
        S_PWDN:       w_nxt = (r_timer == L_PWDN) ? S_SETTLE : S_PWDN;
        S_SETTLE:     w_nxt = (r_timer == L_SETTLE) ? S_INIT_START : S_SETTLE;
        S_INIT_START: w_nxt = S_INIT_WAIT;
        S_INIT_WAIT:  w_nxt = w_done ? S_READY : (r_timer == L_INIT) ? w_to_nxt : S_INIT_WAIT;
`ifdef CAM_PWR_SEQ_RETRY_EN
        S_OFF_RETRY:  w_nxt = (r_timer == L_PWDN) ? S_XCLK : S_OFF_RETRY;
`endif
        default:      w_nxt = r_state;
      endcase
  end
  // Pins are registered from the next state so they change together with r_state.
  always_ff @(posedge clk_1us or negedge reset)
    if (!reset) begin
      r_state    <= S_OFF;
      r_timer    <= '0;
      cam_pwdn   <= 1'b1;
      cam_rst_n  <= 1'b0;
      xclk_en    <= 1'b0;
      init_start <= 1'b0;
      ready      <= 1'b0;
      fault      <= 1'b0;
      state_out  <= C_OFF;
    end else begin
      r_state    <= w_nxt;
      r_timer    <= (w_nxt != r_state) ? '0 : r_timer + 32'd1;
      cam_pwdn   <= w_nxt inside {S_OFF, S_XCLK, S_FAULT, S_OFF_RETRY};
      cam_rst_n  <= w_nxt inside {S_SETTLE, S_INIT_START, S_INIT_WAIT, S_READY};
      xclk_en    <= w_nxt inside {S_XCLK, S_PWDN, S_SETTLE, S_INIT_START, S_INIT_WAIT, S_READY};
      init_start <= w_nxt == S_INIT_START;
      ready      <= w_nxt == S_READY;
      fault      <= w_nxt == S_FAULT;
      state_out  <= seg_code(w_nxt);
    end
endmodule

// File: tb/tb_cam_pwr_seq.sv
// tb_cam_pwr_seq: directed bench for cam_pwr_seq with shortened timings.
module tb_cam_pwr_seq;
  logic       clk_1us = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       init_done = 1'b0;
  logic       cam_pwdn, cam_rst_n, xclk_en, init_start, ready, fault;
  logic [3:0] state_out;
  int n_chk = 0;
  int n_pass = 0;
  int c_xclk, c_pwdn, c_rst, c_ready, c_fault, n_start, n_xrise;
  int st [4];
  always #5 clk_1us = ~clk_1us;
  cam_pwr_seq #(
    .T_XCLK_US   (32'd4),
    .T_PWDN_US   (32'd3),
    .T_SETTLE_US (32'd5),
    .T_INIT_TO_US(32'd20),
    .MAX_RETRIES (4'd2)
  ) dut (
    .clk_1us   (clk_1us),
    .reset     (reset),
    .enable    (enable),
    .init_done (init_done),
    .cam_pwdn  (cam_pwdn),
    .cam_rst_n (cam_rst_n),
    .xclk_en   (xclk_en),
    .init_start(init_start),
    .ready     (ready),
    .fault     (fault),
    .state_out (state_out)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk_1us);
    @(negedge clk_1us);
  endtask
  function automatic logic [9:0] pins();
    return {cam_pwdn, cam_rst_n, xclk_en, init_start, ready, fault, state_out};
  endfunction
  // Cycle 0 is the negedge where enable was raised; records first-event cycles.
  task automatic run(input int ncyc, input int done_on, input int done_off);
    logic px;
    px = xclk_en;
    c_xclk = -1; c_pwdn = -1; c_rst = -1; c_ready = -1; c_fault = -1;
    n_start = 0; n_xrise = 0;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      if (xclk_en && c_xclk < 0) c_xclk = c;
      if (!cam_pwdn && c_pwdn < 0) c_pwdn = c;
      if (cam_rst_n && c_rst < 0) c_rst = c;
      if (ready && c_ready < 0) c_ready = c;
      if (fault && c_fault < 0) c_fault = c;
      if (init_start) begin
        if (n_start < 4) st[n_start] = c;
        n_start++;
      end
      if (xclk_en && !px) n_xrise++;
      px = xclk_en;
      if (c == done_on) init_done = 1'b1;
      if (c == done_off) init_done = 1'b0;
    end
  endtask
  task automatic off();
    enable = 1'b0;
    init_done = 1'b0;
    tick();
    tick();
  endtask
  initial begin
    tick();
    tick();
    chk("reset_pins", 32'(pins()), 32'h200);
    reset = 1'b1;
    tick();
    chk("idle_state", 32'(state_out), 32'd0);
    enable = 1'b1;
    run(20, 15, -1);
    chk("xclk_rise", c_xclk, 1);
    chk("pwdn_fall", c_pwdn, 5);
    chk("rst_rise", c_rst, 8);
    chk("start_cyc", st[0], 13);
    chk("start_cnt", n_start, 1);
    chk("ready_lat", 32'(c_ready >= 16 && c_ready <= 18), 1);
    chk("ready_pins", 32'(pins()), 32'b0110100110);
    off();
`ifndef CAM_PWR_SEQ_RETRY_EN
    enable = 1'b1;
    run(40, -1, -1);
    chk("to_fault_cyc", c_fault, 34);
    chk("to_no_ready", c_ready, -1);
    chk("to_pins", 32'(pins()), 32'b1000010111);
    off();
`else
    enable = 1'b1;
    run(115, -1, -1);
    chk("rt_start_cnt", n_start, 3);
    chk("rt_start0", st[0], 13);
    chk("rt_start1", st[1], 49);
    chk("rt_start2", st[2], 85);
    chk("rt_pwr_cycles", n_xrise, 3);
    chk("rt_fault_cyc", c_fault, 106);
    chk("rt_pins", 32'(pins()), 32'b1000010111);
    off();
    enable = 1'b1;
    run(60, 51, -1);
    chk("rt2_ready_cyc", c_ready, 54);
    chk("rt2_start_cnt", n_start, 2);
    chk("rt2_no_fault", c_fault, -1);
    off();
`endif
    enable = 1'b1;
    run(10, -1, -1);
    chk("ab_settle", 32'(state_out), 32'd3);
    enable = 1'b0;
    tick();
    chk("ab_pins", 32'(pins()), 32'h200);
    enable = 1'b1;
    run(8, -1, -1);
    chk("ab_xclk_rise", c_xclk, 1);
    chk("ab_pwdn_fall", c_pwdn, 5);
    off();
    enable = 1'b1;
    run(36, 31, -1);
    chk("co_ready_cyc", c_ready, 34);
    chk("co_no_fault", c_fault, -1);
    off();
    enable = 1'b1;
    run(30, 9, 10);
    chk("ig_no_ready", c_ready, -1);
    chk("ig_start_cyc", st[0], 13);
    chk("ig_wait", 32'(state_out), 32'd5);
    off();
    enable = 1'b1;
    run(20, -1, -1);
    chk("ar_wait_pins", 32'(pins()), 32'b0110000101);
    #2 reset = 1'b0;
    #1 chk("ar_async_pins", 32'(pins()), 32'h200);
    enable = 1'b0;
    @(negedge clk_1us);
    reset = 1'b1;
    tick();
    chk("ar_post_pins", 32'(pins()), 32'h200);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
